// File: rtl/xbus_arbiter.sv
// Four-requester round-robin bus arbiter with registered one-hot grant,
// optional grant timeout and a one-cycle recovery gap after each release.
module xbus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic [3:0] REQ,
  input  logic [3:0] DONE,
  output logic [3:0] GNT,
  output logic [3:0] GNT_N,
  output logic [1:0] OWNER,
  output logic       BUSY,
  output logic       TOUT
);

  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [3:0]    gnt_n_q;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;
  logic          tout_q, tout_d;

  logic [1:0]    pick_idx;
  logic          pick_found;
  logic          owner_rel;
  logic          tmo_hit;

  // Scan upward from the requester after the last owner, wrapping at 3.
  always_comb begin
    logic [1:0] idx;
    pick_found = 1'b0;
    pick_idx   = last_q;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!pick_found && REQ[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  assign owner_rel = DONE[owner_q] || !REQ[owner_q];
  assign tmo_hit   = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (pick_found) begin
          state_d           = GRANT;
          gnt_d             = 4'b0000;
          gnt_d[pick_idx]   = 1'b1;
          owner_d           = pick_idx;
          cnt_d             = '0;
        end
      end
      GRANT: begin
        if (owner_rel || tmo_hit) begin
          state_d = RECOVER;
          gnt_d   = 4'b0000;
          last_d  = owner_q;
          // A normal release on the same edge as the timeout wins: no pulse.
          tout_d  = tmo_hit && !owner_rel;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECOVER: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      gnt_n_q <= 4'b1111;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gnt_n_q <= ~gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      tout_q  <= tout_d;
    end
  end

  assign GNT   = gnt_q;
  assign GNT_N = gnt_n_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;
  assign TOUT  = tout_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Scoreboard bench for xbus_arbiter: three instances (TIMEOUT 255, 4, 0)
// share stimulus; each scenario checks the instance it targets.
module tb_xbus_arbiter;

  logic       clk;
  logic       clr_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt   [3];
  logic [3:0] gnt_n [3];
  logic [1:0] owner [3];
  logic       busy  [3];
  logic       tout  [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       tout;
  } ent_t;

  ent_t sb[$];

  xbus_arbiter #(.TIMEOUT(255), .CW(8)) u_def (
    .CLK(clk), .CLR_N(clr_n), .REQ(req), .DONE(done),
    .GNT(gnt[0]), .GNT_N(gnt_n[0]), .OWNER(owner[0]), .BUSY(busy[0]), .TOUT(tout[0])
  );
  xbus_arbiter #(.TIMEOUT(4), .CW(8)) u_t4 (
    .CLK(clk), .CLR_N(clr_n), .REQ(req), .DONE(done),
    .GNT(gnt[1]), .GNT_N(gnt_n[1]), .OWNER(owner[1]), .BUSY(busy[1]), .TOUT(tout[1])
  );
  xbus_arbiter #(.TIMEOUT(0), .CW(8)) u_t0 (
    .CLK(clk), .CLR_N(clr_n), .REQ(req), .DONE(done),
    .GNT(gnt[2]), .GNT_N(gnt_n[2]), .OWNER(owner[2]), .BUSY(busy[2]), .TOUT(tout[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                               input logic [1:0] o, input logic b, input logic t);
    ent_t e;
    e.req = r; e.done = d; e.gnt = g; e.owner = o; e.busy = b; e.tout = t;
    sb.push_back(e);
  endfunction

  // Leaves the bench aligned 1 time unit after a posedge, arbiters idle.
  task automatic do_reset();
    req   = 4'b0000;
    done  = 4'b0000;
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req   = 4'b0000;
    done  = 4'b0000;
    clr_n = 1'b0;
    #7;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (gnt[k] !== 4'b0000 || gnt_n[k] !== 4'b1111 || owner[k] !== 2'd0 ||
          busy[k] !== 1'b0 || tout[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs inst=%0d got gnt=%b gnt_n=%b owner=%0d busy=%b tout=%b want 0000 1111 0 0 0",
                 k, gnt[k], gnt_n[k], owner[k], busy[k], tout[k]);
      end
    end
    checks++;
    if (u_def.cnt_q !== 8'd0 || u_def.last_q !== 2'd3) begin
      errors++;
      $display("FAIL reset_internal got cnt=%0d last=%0d want cnt=0 last=3", u_def.cnt_q, u_def.last_q);
    end
    $display("reset check done");
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_grant();
    ent_t e;
    do_reset();
    push(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
    push(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
    push(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      req = e.req; done = e.done;
      @(posedge clk); #1;
      checks++;
      $display("first_grant req=%b done=%b gnt=%b gnt_n=%b owner=%0d busy=%b tout=%b",
               e.req, e.done, gnt[0], gnt_n[0], owner[0], busy[0], tout[0]);
      if (gnt[0] !== e.gnt || gnt_n[0] !== ~e.gnt || owner[0] !== e.owner ||
          busy[0] !== e.busy || tout[0] !== e.tout) begin
        errors++;
        $display("FAIL first_grant got gnt=%b gnt_n=%b owner=%0d busy=%b tout=%b want gnt=%b owner=%0d busy=%b tout=%b",
                 gnt[0], gnt_n[0], owner[0], busy[0], tout[0], e.gnt, e.owner, e.busy, e.tout);
      end
    end
  endtask

  task automatic test_round_robin();
    ent_t e;
    logic [3:0] g;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      g = 4'b0001 << (n % 4);
      push(4'b1111, 4'b0000, g,       2'(n % 4), 1'b1, 1'b0);
      push(4'b1111, g,       4'b0000, 2'(n % 4), 1'b1, 1'b0);
      push(4'b1111, 4'b0000, 4'b0000, 2'(n % 4), 1'b0, 1'b0);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      req = e.req; done = e.done;
      @(posedge clk); #1;
      checks++;
      $display("round_robin req=%b done=%b gnt=%b owner=%0d busy=%b tout=%b",
               e.req, e.done, gnt[0], owner[0], busy[0], tout[0]);
      if (gnt[0] !== e.gnt || gnt_n[0] !== ~e.gnt || owner[0] !== e.owner ||
          busy[0] !== e.busy || tout[0] !== e.tout) begin
        errors++;
        $display("FAIL round_robin got gnt=%b gnt_n=%b owner=%0d busy=%b tout=%b want gnt=%b owner=%0d busy=%b tout=%b",
                 gnt[0], gnt_n[0], owner[0], busy[0], tout[0], e.gnt, e.owner, e.busy, e.tout);
      end
    end
  endtask

  task automatic test_timeout();
    ent_t e;
    do_reset();
    for (int n = 0; n < 4; n++) push(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    push(4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b1);
    push(4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    push(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      req = e.req; done = e.done;
      @(posedge clk); #1;
      checks++;
      $display("timeout req=%b done=%b gnt=%b owner=%0d busy=%b tout=%b",
               e.req, e.done, gnt[1], owner[1], busy[1], tout[1]);
      if (gnt[1] !== e.gnt || gnt_n[1] !== ~e.gnt || owner[1] !== e.owner ||
          busy[1] !== e.busy || tout[1] !== e.tout) begin
        errors++;
        $display("FAIL timeout got gnt=%b gnt_n=%b owner=%0d busy=%b tout=%b want gnt=%b owner=%0d busy=%b tout=%b",
                 gnt[1], gnt_n[1], owner[1], busy[1], tout[1], e.gnt, e.owner, e.busy, e.tout);
      end
    end
  endtask

  task automatic test_done_at_limit();
    ent_t e;
    do_reset();
    for (int n = 0; n < 4; n++) push(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
    push(4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);
    push(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      req = e.req; done = e.done;
      @(posedge clk); #1;
      checks++;
      $display("done_at_limit req=%b done=%b gnt=%b owner=%0d busy=%b tout=%b",
               e.req, e.done, gnt[1], owner[1], busy[1], tout[1]);
      if (gnt[1] !== e.gnt || gnt_n[1] !== ~e.gnt || owner[1] !== e.owner ||
          busy[1] !== e.busy || tout[1] !== e.tout) begin
        errors++;
        $display("FAIL done_at_limit got gnt=%b gnt_n=%b owner=%0d busy=%b tout=%b want gnt=%b owner=%0d busy=%b tout=%b",
                 gnt[1], gnt_n[1], owner[1], busy[1], tout[1], e.gnt, e.owner, e.busy, e.tout);
      end
    end
  endtask

  task automatic test_nonowner_and_reset();
    ent_t e;
    do_reset();
    push(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
    push(4'b0010, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0);
    push(4'b0011, 4'b1001, 4'b0010, 2'd1, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      req = e.req; done = e.done;
      @(posedge clk); #1;
      checks++;
      $display("nonowner req=%b done=%b gnt=%b owner=%0d busy=%b tout=%b",
               e.req, e.done, gnt[0], owner[0], busy[0], tout[0]);
      if (gnt[0] !== e.gnt || gnt_n[0] !== ~e.gnt || owner[0] !== e.owner ||
          busy[0] !== e.busy || tout[0] !== e.tout) begin
        errors++;
        $display("FAIL nonowner got gnt=%b gnt_n=%b owner=%0d busy=%b tout=%b want gnt=%b owner=%0d busy=%b tout=%b",
                 gnt[0], gnt_n[0], owner[0], busy[0], tout[0], e.gnt, e.owner, e.busy, e.tout);
      end
    end
    #2;
    clr_n = 1'b0;
    #1;
    checks++;
    $display("async_reset gnt=%b gnt_n=%b busy=%b tout=%b", gnt[0], gnt_n[0], busy[0], tout[0]);
    if (gnt[0] !== 4'b0000 || gnt_n[0] !== 4'b1111 || busy[0] !== 1'b0 || tout[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got gnt=%b gnt_n=%b busy=%b tout=%b want 0000 1111 0 0",
               gnt[0], gnt_n[0], busy[0], tout[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_no_timeout();
    ent_t e;
    do_reset();
    for (int n = 0; n < 300; n++) push(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      req = e.req; done = e.done;
      @(posedge clk); #1;
      checks++;
      $display("no_timeout gnt=%b owner=%0d busy=%b tout=%b cnt=%0d",
               gnt[2], owner[2], busy[2], tout[2], u_t0.cnt_q);
      if (gnt[2] !== e.gnt || gnt_n[2] !== ~e.gnt || owner[2] !== e.owner ||
          busy[2] !== e.busy || tout[2] !== e.tout) begin
        errors++;
        $display("FAIL no_timeout got gnt=%b gnt_n=%b owner=%0d busy=%b tout=%b want gnt=%b owner=%0d busy=%b tout=%b",
                 gnt[2], gnt_n[2], owner[2], busy[2], tout[2], e.gnt, e.owner, e.busy, e.tout);
      end
    end
    checks++;
    if (u_t0.cnt_q !== 8'd255) begin
      errors++;
      $display("FAIL counter_saturate got cnt=%0d want 255", u_t0.cnt_q);
    end
  endtask

  initial begin
    clr_n = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;
    test_reset();
    test_first_grant();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_nonowner_and_reset();
    test_no_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbus_arbiter.md
XBUS_ARBITER -- requirements
Module: xbus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max GRANT-state cycles before forced release; 0 disables timeout.
REQ-002 Parameter CW, default 8, meaning timeout counter width in bits; TIMEOUT SHALL be at most 2^CW-1.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 CLR_N  input  1  asynchronous active-low reset.
REQ-005 REQ  input  4  per-requester bus request, level-sensitive.
REQ-006 DONE  input  4  per-requester release strobe; only the current owner's bit is honoured.
REQ-007 GNT  output  4  registered one-hot grant; all zero when no owner.
REQ-008 GNT_N  output  4  bitwise complement of GNT, registered on the same edge, never skewed from GNT.
REQ-009 OWNER  output  2  index of the current or last owner.
REQ-010 BUSY  output  1  high while in GRANT or RECOVER.
REQ-011 TOUT  output  1  one-cycle pulse on forced release.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and RECOVER.
REQ-013 In IDLE with REQ==0, the FSM SHALL stay in IDLE with GNT=0000.
REQ-014 In IDLE with REQ!=0, the FSM SHALL pick the winner by round-robin, scanning from index (LAST+1) mod 4 upward with wrap, where LAST is the internal 2-bit index of the previous owner.
REQ-015 The winner's GNT bit, OWNER and BUSY=1 SHALL be visible immediately after the edge that sampled REQ (1-clock latency), and the FSM SHALL enter GRANT.
REQ-016 On grant, the timeout counter SHALL clear to 0.
REQ-017 In GRANT, the counter SHALL increment by 1 per cycle, saturating at 2^CW-1.
REQ-018 In GRANT, the grant SHALL be released at the next edge when the owner's DONE bit is sampled high or the owner's REQ bit is sampled low.
REQ-019 In GRANT with TIMEOUT!=0, the grant SHALL be released when the counter equals TIMEOUT-1 at a sampled edge, so GNT is held exactly TIMEOUT cycles.
REQ-020 A forced release per REQ-019 SHALL assert TOUT for exactly the one cycle following the release edge.
REQ-021 On any release, GNT SHALL go to 0000, LAST SHALL take the owner index, OWNER SHALL hold its value, and the FSM SHALL enter RECOVER.
REQ-022 RECOVER SHALL last exactly one cycle with GNT=0000 and BUSY=1, then go to IDLE; REQ is ignored during RECOVER.
REQ-023 DONE or REQ changes from non-owners SHALL have no effect during GRANT.
REQ-024 DONE in IDLE or RECOVER SHALL have no effect.
REQ-025 If owner DONE (or REQ drop) and the timeout condition occur on the same edge, the release SHALL be normal and TOUT SHALL stay 0.
REQ-026 Back-to-back service SHALL be: release edge, one RECOVER cycle, IDLE cycle sampling REQ, then the next grant; the minimum gap with GNT=0000 is 2 cycles.
REQ-027 At most one GNT bit SHALL be high in any cycle, including across reset.

Reset
REQ-028 While CLR_N=0, independent of CLK, the following SHALL hold: GNT=0000, GNT_N=1111, OWNER=00, BUSY=0, TOUT=0, counter=0, LAST=3, state=IDLE.
REQ-029 CLR_N asserted mid-GRANT SHALL drop GNT combinationally with reset, without waiting for a clock edge, and SHALL NOT pulse TOUT.
REQ-030 The first arbitration after reset SHALL favour requester 0.

Verification
REQ-031 Reset release, REQ=0001 at edge N -> after edge N: GNT=0001, GNT_N=1110, OWNER=0, BUSY=1.
REQ-032 REQ=1111 held, owner pulses DONE one cycle after each grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with 2 GNT=0000 cycles between grants.
REQ-033 TIMEOUT=4, REQ=0100 held, no DONE -> GNT=0100 for exactly 4 cycles, then TOUT=1 for 1 cycle, GNT=0000, BUSY=1 for 1 RECOVER cycle.
REQ-034 TIMEOUT=4, owner DONE on the 4th GRANT cycle -> release with TOUT=0.
REQ-035 Owner 1 granted, DONE=0001 pulsed -> GNT stays 0010; then CLR_N=0 mid-grant -> GNT=0000, GNT_N=1111 before the next CLK edge.
REQ-036 TIMEOUT=0, REQ=1000 held 300 cycles, no DONE -> GNT=1000 throughout, TOUT never asserted, counter saturated at 255 without wrap.
